// File: rtl/axil_led_sequencer.sv
// AXI4-Lite master that periodically writes an LED pattern, reads the status back and flags differences.
// Defining LED_SEQ_TIMEOUT_EN adds a per-state handshake watchdog limited to TIMEOUT cycles.
module axil_led_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
  parameter logic [31:0] WR_OFFSET = 32'd0,
  parameter logic [31:0] RD_OFFSET = 32'd4,
  parameter int          LED_W     = 4,
  parameter int          PERIOD    = 1000,
  parameter int          TIMEOUT   = 256
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             mode,
  input  logic             clear,
  output logic [31:0]      m_axi_awaddr,
  output logic [2:0]       m_axi_awprot,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic [31:0]      m_axi_araddr,
  output logic [2:0]       m_axi_arprot,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [31:0]      m_axi_rdata,
  input  logic [1:0]       m_axi_rresp,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready,
  output logic [LED_W-1:0] pattern,
  output logic [15:0]      seq_count,
  output logic             busy,
  output logic             mismatch,
  output logic             resp_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_BRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);

  state_t           state_r;
  logic [31:0]      timer_r;
  logic [LED_W-1:0] pattern_r;
  logic [15:0]      seq_count_r;
  logic             awvalid_r;
  logic             wvalid_r;
  logic             bready_r;
  logic             arvalid_r;
  logic             rready_r;
  logic             busy_r;
  logic             mismatch_r;
  logic             resp_err_r;

  logic [LED_W-1:0] next_pattern_s;
  logic             start_s;
  logic             timer_done_s;
  logic             aw_done_s;
  logic             w_done_s;
  logic             rd_mismatch_s;
  logic             wd_expired_s;
  logic             unused_s;

  function automatic logic is_onehot(input logic [LED_W-1:0] p);
    return (p != {LED_W{1'b0}}) && ((p & (p - LED_W'(1'b1))) == {LED_W{1'b0}});
  endfunction

  assign timer_done_s  = (timer_r >= PERIOD_M1);
  assign aw_done_s     = !awvalid_r || m_axi_awready;
  assign w_done_s      = !wvalid_r || m_axi_wready;
  assign rd_mismatch_s = (m_axi_rdata[LED_W-1:0] != pattern_r);

  // Next pattern: binary count-up, or walking-one that reseeds from 1 when not one-hot.
  always_comb begin
    next_pattern_s = pattern_r;
    if (mode == 1'b0) begin
      next_pattern_s = pattern_r + LED_W'(1'b1);
    end else if (is_onehot(pattern_r)) begin
      next_pattern_s = (pattern_r << 1) | (pattern_r >> (LED_W - 1));
    end else begin
      next_pattern_s = LED_W'(1'b1);
    end
  end

  // A sequence starts from IDLE at once, or from WAIT once the period has elapsed.
  always_comb begin
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: start_s = enable;
      ST_WAIT: start_s = enable && timer_done_s;
      default: start_s = 1'b0;
    endcase
  end

  // Cycles since the last WR entry; saturates so an overlong stall cannot wrap it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_r <= 32'd0;
    end else if (start_s) begin
      timer_r <= 32'd0;
    end else if (timer_r != 32'hFFFF_FFFF) begin
      timer_r <= timer_r + 32'd1;
    end
  end

`ifdef LED_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t      prev_state_r;
  logic [31:0] wd_r;
  logic [31:0] wd_count_s;

  assign wd_count_s   = (state_r != prev_state_r) ? 32'd0 : wd_r;
  assign wd_expired_s = (wd_count_s >= TIMEOUT_M1);
  assign unused_s     = ^m_axi_rdata;

  // Watchdog: cycles spent in the current state, restarted on every state change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_state_r <= ST_IDLE;
      wd_r         <= 32'd0;
    end else begin
      prev_state_r <= state_r;
      if (wd_count_s != 32'hFFFF_FFFF) begin
        wd_r <= wd_count_s + 32'd1;
      end
    end
  end
`else
  assign wd_expired_s = 1'b0;
  assign unused_s     = ^{m_axi_rdata, 32'(TIMEOUT)};
`endif

  // Sequencer FSM; flag sets are written after clear so a coincident set wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      pattern_r   <= {LED_W{1'b0}};
      seq_count_r <= 16'd0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      busy_r      <= 1'b0;
      mismatch_r  <= 1'b0;
      resp_err_r  <= 1'b0;
    end else begin
      if (clear) begin
        seq_count_r <= 16'd0;
        mismatch_r  <= 1'b0;
        resp_err_r  <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_WR;
            pattern_r <= next_pattern_s;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        ST_WR: begin
          if (awvalid_r && m_axi_awready) awvalid_r <= 1'b0;
          if (wvalid_r && m_axi_wready) wvalid_r <= 1'b0;
          if (aw_done_s && w_done_s) begin
            state_r  <= ST_BRESP;
            bready_r <= 1'b1;
          end else if (wd_expired_s) begin
            state_r    <= ST_WAIT;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            resp_err_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_BRESP: begin
          if (m_axi_bvalid) begin
            state_r   <= ST_RD;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b1;
            if (m_axi_bresp != 2'b00) resp_err_r <= 1'b1;
          end else if (wd_expired_s) begin
            state_r    <= ST_WAIT;
            bready_r   <= 1'b0;
            resp_err_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_RD: begin
          if (m_axi_arready) begin
            state_r   <= ST_RDATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end else if (wd_expired_s) begin
            state_r    <= ST_WAIT;
            arvalid_r  <= 1'b0;
            resp_err_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            state_r     <= ST_WAIT;
            rready_r    <= 1'b0;
            busy_r      <= 1'b0;
            seq_count_r <= clear ? 16'd1 : seq_count_r + 16'd1;
            if (rd_mismatch_s) mismatch_r <= 1'b1;
            if (m_axi_rresp != 2'b00) resp_err_r <= 1'b1;
          end else if (wd_expired_s) begin
            state_r    <= ST_WAIT;
            rready_r   <= 1'b0;
            resp_err_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (start_s) begin
            state_r   <= ST_WR;
            pattern_r <= next_pattern_s;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            busy_r    <= 1'b1;
          end else if (timer_done_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign m_axi_awaddr  = BASE_ADDR + WR_OFFSET;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = 32'(pattern_r);
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = BASE_ADDR + RD_OFFSET;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;
  assign pattern       = pattern_r;
  assign seq_count     = seq_count_r;
  assign busy          = busy_r;
  assign mismatch      = mismatch_r;
  assign resp_err      = resp_err_r;

endmodule

// File: tb/tb_axil_led_sequencer.sv
// Directed bench for axil_led_sequencer: a scripted AXI4-Lite slave plus a queue of expected write patterns.
// With LED_SEQ_TIMEOUT_EN defined it also covers the watchdog path.
module tb_axil_led_sequencer;

  localparam logic [31:0] BASE = 32'hC000_0000;
`ifdef LED_SEQ_TIMEOUT_EN
  localparam int PER = 400;
`else
  localparam int PER = 64;
`endif
  localparam int TMO = 256;

  logic        aclk;
  logic        aresetn, enable, mode, clear;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb, pattern;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [15:0] seq_count;
  logic        busy, mismatch, resp_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          prev_aw;
  logic [3:0]  exp_pat;
  logic        exp_mm, exp_re;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_q[$];

  axil_led_sequencer #(
    .BASE_ADDR(BASE), .WR_OFFSET(32'd0), .RD_OFFSET(32'd4),
    .LED_W(4), .PERIOD(PER), .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode), .clear(clear),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .pattern(pattern), .seq_count(seq_count), .busy(busy),
    .mismatch(mismatch), .resp_err(resp_err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pattern sequence, written independently of the design.
  function automatic logic [3:0] model_next(input logic [3:0] p, input logic m);
    if (!m) return p + 4'd1;
    case (p)
      4'd1:    return 4'd2;
      4'd2:    return 4'd4;
      4'd4:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  task automatic push_next();
    exp_pat = model_next(exp_pat, mode);
    exp_q.push_back(exp_pat);
  endtask

  task automatic clear_model();
    exp_pat = 4'd0; exp_mm = 1'b0; exp_re = 1'b0; exp_cnt = 16'd0;
    exp_q.delete();
    prev_aw = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
    check({tag, "_wvalid"}, m_axi_wvalid, 1'b0);
    check({tag, "_bready"}, m_axi_bready, 1'b0);
    check({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, "_rready"}, m_axi_rready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mismatch"}, mismatch, 1'b0);
    check({tag, "_resp_err"}, resp_err, 1'b0);
    check({tag, "_seq_count"}, seq_count, 16'd0);
    check({tag, "_pattern"}, pattern, 4'd0);
  endtask

  task automatic idle_slave();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0;
    idle_slave();
    repeat (3) @(negedge aclk);
    clear_model();
    check_reset_outputs("rst");
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge aclk);
      if (m_axi_awvalid !== 1'b0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One full sequence served by the slave; lead = cycles wready precedes awready.
  task automatic run_seq(input int lead, input logic [1:0] bresp_v, input bit bad_rd,
                         input logic [31:0] bad_data, input bit clr_on_r, input bit drop_en,
                         input bit rst_mid, input bit ar_hang);
    bit          ok;
    int          aw_cyc;
    int          n_high;
    logic [3:0]  exp_w;
    logic [31:0] slave_mem, rd_val;
    ok = 1'b0;
    for (int n = 0; n < 4 * PER && !ok; n++) begin
      @(negedge aclk);
      if (m_axi_awvalid === 1'b1) ok = 1'b1;
    end
    check("aw_start", ok, 1'b1);
    if (!ok) return;
    aw_cyc = cyc;
    if (prev_aw >= 0) check("aw_spacing", 32'(aw_cyc - prev_aw), 32'(PER));
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    else exp_w = 4'hx;
    check("awaddr", m_axi_awaddr, BASE);
    check("wdata", m_axi_wdata, {28'd0, exp_w});
    check("wvalid_with_aw", m_axi_wvalid, 1'b1);
    check("busy_wr", busy, 1'b1);
    check("wstrb", m_axi_wstrb, 4'hF);
    check("awprot", m_axi_awprot, 3'd0);
    slave_mem = m_axi_wdata;
    if (drop_en) enable = 1'b0;
    for (int k = 0; k <= lead; k++) begin
      if (k > 0) begin
        check("wvalid_dropped", m_axi_wvalid, 1'b0);
        check("awvalid_held", m_axi_awvalid, 1'b1);
        check("awaddr_stable", m_axi_awaddr, BASE);
        check("bready_early", m_axi_bready, 1'b0);
      end
      m_axi_wready = (k == 0);
      m_axi_awready = (k == lead);
      @(negedge aclk);
    end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("aw_done", m_axi_awvalid, 1'b0);
    check("w_done", m_axi_wvalid, 1'b0);
    check("bready_on", m_axi_bready, 1'b1);
    check("arvalid_before_b", m_axi_arvalid, 1'b0);
    m_axi_bvalid = 1'b1; m_axi_bresp = bresp_v;
    @(negedge aclk);
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    if (bresp_v != 2'b00) exp_re = 1'b1;
    check("bready_once", m_axi_bready, 1'b0);
    check("arvalid_on", m_axi_arvalid, 1'b1);
    check("araddr", m_axi_araddr, BASE + 32'd4);
    check("arprot", m_axi_arprot, 3'd0);
    check("resp_err_after_b", resp_err, exp_re);
    if (ar_hang) begin
      n_high = 0;
      for (int k = 0; k < 3 * TMO && m_axi_arvalid === 1'b1; k++) begin
        n_high++;
        @(negedge aclk);
      end
      exp_re = 1'b1;
      check("arvalid_cycles", 32'(n_high), 32'(TMO));
      check("timeout_resp_err", resp_err, exp_re);
      check("timeout_rready", m_axi_rready, 1'b0);
      check("timeout_busy", busy, 1'b0);
      check("timeout_seq_count", seq_count, exp_cnt);
      prev_aw = aw_cyc;
      return;
    end
    m_axi_arready = 1'b1;
    @(negedge aclk);
    m_axi_arready = 1'b0;
    check("ar_done", m_axi_arvalid, 1'b0);
    check("rready_on", m_axi_rready, 1'b1);
    if (rst_mid) begin
      enable = 1'b0;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge aclk);
      aresetn = 1'b1;
      clear_model();
      return;
    end
    rd_val = bad_rd ? bad_data : slave_mem;
    m_axi_rvalid = 1'b1; m_axi_rdata = rd_val; m_axi_rresp = 2'b00; clear = clr_on_r;
    if (clr_on_r) begin
      exp_mm = 1'b0;
      exp_re = 1'b0;
    end
    if (rd_val[3:0] != exp_w) exp_mm = 1'b1;
    exp_cnt = clr_on_r ? 16'd1 : exp_cnt + 16'd1;
    @(negedge aclk);
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; clear = 1'b0;
    check("rready_once", m_axi_rready, 1'b0);
    check("mismatch", mismatch, exp_mm);
    check("resp_err", resp_err, exp_re);
    check("seq_count", seq_count, exp_cnt);
    check("pattern", pattern, exp_w);
    check("busy_wait", busy, 1'b0);
    prev_aw = aw_cyc;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
    exp_mm = 1'b0; exp_re = 1'b0; exp_cnt = 16'd0;
    check("clear_mismatch", mismatch, exp_mm);
    check("clear_resp_err", resp_err, exp_re);
    check("clear_seq_count", seq_count, exp_cnt);
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; mode = 1'b0; clear = 1'b0;
    idle_slave();
    clear_model();

    // Count-up with an ideal slave; enable drops during the third sequence.
    do_reset();
    mode = 1'b0; enable = 1'b1;
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_idle(3 * PER, "stop_after_disable");

    // Walking-one from reset: 1,2,4,8,1,2 then a W-before-AW handshake.
    do_reset();
    mode = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    push_next(); run_seq(3, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bad read-back of 5 after writing 3; mismatch stays sticky until cleared.
    do_reset();
    mode = 1'b0; enable = 1'b1;
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    push_next(); run_seq(0, 2'b00, 1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // SLVERR on write still completes the read; then reset lands in RDATA.
    push_next(); run_seq(0, 2'b10, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_idle(2 * PER, "no_resume_after_reset");
    check_reset_outputs("post_rst");

`ifdef LED_SEQ_TIMEOUT_EN
    // arready never arrives: watchdog fires, next sequence keeps the period.
    do_reset();
    mode = 1'b0; enable = 1'b1;
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_next(); run_seq(0, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
